// File: rtl/diag_wavefront_sender_if.sv
// Handshake bundle between the wavefront sender and the activation layer.
// The sender drives slices; the sink returns ready/done status.
interface diag_wavefront_sender_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_VALUES = 5
);
  logic                             act_start;
  logic                             act_input_done;
  logic [DATA_WIDTH*NUM_VALUES-1:0] act_in_value;
  logic                             act_ready;
  logic                             act_output_done;
  logic                             act_output_complete;

  modport master (
    output act_start,
    output act_input_done,
    output act_in_value,
    input  act_ready,
    input  act_output_done,
    input  act_output_complete
  );

  modport slave (
    input  act_start,
    input  act_input_done,
    input  act_in_value,
    output act_ready,
    output act_output_done,
    output act_output_complete
  );
endinterface

// File: rtl/diag_wavefront_sender.sv
// Latches an accumulator matrix and streams it as diagonal L-slices.
// Optional watchdog enabled by defining DIAG_SEND_TIMEOUT_EN.
module diag_wavefront_sender #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAT_ROWS       = 3,
  parameter int MAT_COLS       = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic [DATA_WIDTH*MAT_ROWS*MAT_COLS-1:0] mat_in,
  output logic busy,
  output logic done,
  output logic timeout_err,
  diag_wavefront_sender_if.master act
);

  localparam int NUM_VALUES = MAT_ROWS + MAT_COLS - 1;
  localparam int NUM_DIAGS  =
    (MAT_ROWS < MAT_COLS) ? MAT_ROWS : MAT_COLS;
  localparam int DIAG_W =
    (NUM_DIAGS > 1) ? $clog2(NUM_DIAGS) : 1;
  localparam int DW = DATA_WIDTH;
  localparam int MW = DW * MAT_ROWS * MAT_COLS;
  localparam int VW = DW * NUM_VALUES;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [MW-1:0]     mat_q;
  logic [DIAG_W-1:0] diag;
  logic [VW-1:0]     slice;
  logic [VW-1:0]     value_q;
  logic              start_q;
  logic              last_q;
  logic              last;
  logic              cap;
  logic              fire;
  logic              adv;
  logic              fin;
  logic              tmo;

  assign last = (diag == DIAG_W'(NUM_DIAGS - 1));

  // Row segment from the corner rightwards, then column below it.
  always_comb begin
    slice = '0;
    for (int dd = 0; dd < NUM_DIAGS; dd++) begin
      if (diag == DIAG_W'(dd)) begin
        for (int i = 0; i < MAT_COLS; i++) begin
          if (i < MAT_COLS - dd) begin
            slice[DW*i +: DW] =
              mat_q[DW*(dd*MAT_COLS+dd+i) +: DW];
          end
        end
        for (int j = 0; j < MAT_ROWS - 1; j++) begin
          if (j < MAT_ROWS - dd - 1) begin
            slice[DW*(MAT_COLS+j) +: DW] =
              mat_q[DW*((dd+1+j)*MAT_COLS+dd) +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (load) state_n = ISSUE;
      ISSUE:
        if (act.act_ready) state_n = WAIT;
      WAIT:
        if (act.act_output_done)
          state_n = last ? FINISH : ISSUE;
      FINISH:
        if (act.act_output_complete) state_n = IDLE;
    endcase
    if (tmo) state_n = IDLE;
  end

  always_comb begin
    cap  = 1'b0;
    fire = 1'b0;
    adv  = 1'b0;
    fin  = 1'b0;
    unique case (state)
      IDLE:   cap  = load;
      ISSUE:  fire = act.act_ready & ~tmo;
      WAIT:   adv  = act.act_output_done & ~tmo;
      FINISH: fin  = act.act_output_complete & ~tmo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mat_q   <= '0;
      diag    <= '0;
      value_q <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      start_q <= fire;
      last_q  <= fire & last;
      done    <= fin;
      if (cap) begin
        mat_q <= mat_in;
        diag  <= '0;
        busy  <= 1'b1;
      end
      if (fin | tmo) busy <= 1'b0;
      if (adv & ~last) diag <= diag + 1'b1;
      if (state == ISSUE) value_q <= slice;
    end
  end

  assign act.act_start      = start_q;
  assign act.act_input_done = last_q;
  assign act.act_in_value   = value_q;

`ifdef DIAG_SEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // Counter restarts whenever the FSM moves, so it bounds each stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE || state_n != state) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (tmo) err_q <= 1'b1;
    end
  end

  assign tmo = (state != IDLE) &&
               (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;
`else
  assign tmo         = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_diag_wavefront_sender.sv
// Scoreboard bench for diag_wavefront_sender, 3x3 of 32-bit elements.
// Timeout scenario runs only when DIAG_SEND_TIMEOUT_EN is defined.
module tb_diag_wavefront_sender;

  typedef struct {
    logic [159:0] v;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [287:0] mat_in;
  logic         busy;
  logic         done;
  logic         timeout_err;

  int checks;
  int errors;
  int got_done;
  int exp_done;
  exp_t exp_q[$];

  logic [287:0] mat_a;
  logic [287:0] mat_b;
  logic [159:0] s0;
  logic [159:0] s1;
  logic [159:0] s2;

  diag_wavefront_sender_if #(
    .DATA_WIDTH(32),
    .NUM_VALUES(5)
  ) aif ();

  diag_wavefront_sender #(
    .DATA_WIDTH(32),
    .MAT_ROWS(3),
    .MAT_COLS(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .mat_in(mat_in),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err),
    .act(aif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [287:0] mk(int base);
    logic [287:0] m;
    m = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        m[32*(r*3+c) +: 32] = 32'(base + 10*r + c + 1);
    return m;
  endfunction

  function automatic logic [159:0] pk(
    int a, int b, int c, int d, int e
  );
    return {32'(e), 32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk(
    string name, logic [159:0] act, logic [159:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all();
    exp_q.push_back('{s0, 1'b0});
    exp_q.push_back('{s1, 1'b0});
    exp_q.push_back('{s2, 1'b1});
  endtask

  task automatic load_mat(logic [287:0] m);
    mat_in = m;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!aif.act_start && n < 40) begin
      tick();
      n++;
    end
    if (!aif.act_start) chk("start_timeout", 0, 1);
  endtask

  task automatic serve();
    repeat (2) tick();
    aif.act_output_done = 1'b1;
    tick();
    aif.act_output_done = 1'b0;
  endtask

  task automatic run_from(bit first_seen);
    for (int s = 0; s < 3; s++) begin
      if (!(s == 0 && first_seen)) begin
        tick();
        wait_start();
      end
      serve();
    end
  endtask

  task automatic finish_mat();
    int n;
    repeat (5) tick();
    chk("finish_hold", {busy, done}, 2'b10);
    aif.act_output_complete = 1'b1;
    exp_done++;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("done_busy", {done, busy}, 2'b10);
    aif.act_output_complete = 1'b0;
    tick();
    chk("done_once", {done, busy}, 2'b00);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) got_done++;
    if (rst_n && aif.act_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("slice_value", aif.act_in_value, e.v);
        chk("input_done", aif.act_input_done, e.last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    checks   = 0;
    errors   = 0;
    got_done = 0;
    exp_done = 0;
    mat_a = mk(0);
    mat_b = mk(1000);
    s0 = pk(1, 2, 3, 11, 21);
    s1 = pk(12, 13, 0, 22, 0);
    s2 = pk(23, 0, 0, 0, 0);
    rst_n  = 1'b0;
    load   = 1'b0;
    mat_in = '0;
    aif.act_ready           = 1'b0;
    aif.act_output_done     = 1'b0;
    aif.act_output_complete = 1'b0;
    repeat (2) tick();
    chk("reset_outputs",
        {busy, done, timeout_err, aif.act_start,
         aif.act_input_done}, 5'b0);
    chk("reset_value", aif.act_in_value, '0);
    rst_n = 1'b1;
    tick();

    // full matrix, ready held high, 2-cycle latency
    aif.act_ready = 1'b1;
    push_all();
    load_mat(mat_a);
    chk("busy_after_load", {busy, aif.act_start}, 2'b10);
    tick();
    chk("latency2", aif.act_start, 1);
    run_from(1);
    finish_mat();

    // ready held low for 10 cycles
    aif.act_ready = 1'b0;
    push_all();
    load_mat(mat_a);
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (aif.act_start) starts++;
    end
    chk("no_start_unready", starts, 0);
    aif.act_ready = 1'b1;
    tick();
    chk("start_after_ready", aif.act_start, 1);
    run_from(1);
    finish_mat();

    // load during WAIT is ignored
    push_all();
    load_mat(mat_a);
    tick();
    wait_start();
    mat_in = mat_b;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    tick();
    aif.act_output_done = 1'b1;
    tick();
    aif.act_output_done = 1'b0;
    for (int s = 1; s < 3; s++) begin
      tick();
      wait_start();
      serve();
    end
    finish_mat();

    // reset during WAIT of slice1
    push_all();
    load_mat(mat_a);
    tick();
    wait_start();
    serve();
    tick();
    wait_start();
    rst_n = 1'b0;
    tick();
    chk("midreset_outputs",
        {busy, done, timeout_err, aif.act_start,
         aif.act_input_done}, 5'b0);
    chk("midreset_value", aif.act_in_value, '0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_after_reset", {busy, aif.act_start}, 2'b00);
    push_all();
    load_mat(mat_a);
    tick();
    wait_start();
    run_from(1);
    finish_mat();

`ifdef DIAG_SEND_TIMEOUT_EN
    exp_q.push_back('{s0, 1'b0});
    load_mat(mat_a);
    tick();
    wait_start();
    repeat (15) tick();
    chk("tmo_not_yet", timeout_err, 0);
    tick();
    chk("tmo_fired", {timeout_err, busy, done}, 3'b100);
    repeat (5) tick();
    chk("tmo_sticky", {timeout_err, busy}, 2'b10);
`endif

    repeat (3) tick();
    chk("done_count", got_done, exp_done);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
